// File: rtl/i2c_slave_regbank.sv
// Register-bank back end for the I2C slave engine: register-address parsing,
// auto-increment pointer with optional page wrap, write protection and an arbitrated host port.
module i2c_slave_regbank #(
  parameter int AW        = 8,
  parameter int PAGE_LOG2 = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_reg_addr_16bit,
  input  logic             cfg_auto_inc,
  input  logic             cfg_page_wrap,
  input  logic             cfg_wp_en,
  input  logic [15:0]      cfg_wp_base,
  input  logic             i2c_sel,
  input  logic             i2c_rnw,
  input  logic             i2c_rx_valid,
  input  logic [7:0]       i2c_rx_data,
  input  logic             i2c_tx_ack,
  output logic             i2c_tx_valid,
  output logic [7:0]       i2c_tx_data,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             host_ack,
  output logic [15:0]      ptr,
  output logic             busy,
  output logic             wr_evt,
  output logic [AW-1:0]    wr_evt_addr,
  output logic [CNT_W-1:0] wp_hit_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;

  logic [7:0] mem [0:(2**AW)-1];

  logic [2:0]    state;
  logic          sel_d;
  logic          rise;
  logic          sel_drop;
  logic [15:0]   ptr_adv;
  logic          wp_block;
  logic          i2c_wr;
  logic          wp_drop;
  logic          i2c_rd_start;
  logic          i2c_rd_next;
  logic          i2c_rd;
  logic [AW-1:0] i2c_rd_addr;
  logic          host_grant;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  // Low PAGE_LOG2 bits roll over inside the page; upper bits are left alone.
  function automatic logic [15:0] ptr_advance(input logic [15:0] p, input logic inc,
                                              input logic wrap);
    logic [15:0] mask;
    mask = 16'((32'd1 << PAGE_LOG2) - 32'd1);
    if (!inc)
      return p;
    if (wrap)
      return (p & ~mask) | ((p + 16'd1) & mask);
    return p + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign rise         = i2c_sel & ~sel_d;
  assign sel_drop     = (state != S_IDLE) & ~i2c_sel;
  assign ptr_adv      = ptr_advance(ptr, cfg_auto_inc, cfg_page_wrap);
  assign wp_block     = cfg_wp_en & (ptr >= cfg_wp_base);
  assign i2c_wr       = (state == S_WR_DATA) & i2c_sel & i2c_rx_valid & ~wp_block;
  assign wp_drop      = (state == S_WR_DATA) & i2c_sel & i2c_rx_valid & wp_block;
  assign i2c_rd_start = (state == S_IDLE) & rise & i2c_rnw;
  assign i2c_rd_next  = (state == S_RD_DATA) & i2c_sel & i2c_tx_ack;
  assign i2c_rd       = i2c_rd_start | i2c_rd_next;
  // After a tx_ack the byte to present is the one at the advanced pointer.
  assign i2c_rd_addr  = i2c_rd_start ? ptr[AW-1:0] : ptr_adv[AW-1:0];
  assign busy         = (state != S_IDLE);

  // The host only gets the RAM in cycles the I2C side leaves it free; the
  // host_ack term stops a still-held request from being granted twice.
  assign host_grant = host_req & ~host_ack & ~(i2c_wr | i2c_rd);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = host_wdata;
    if (i2c_wr) begin
      mem_we    = rst_n;
      mem_waddr = ptr[AW-1:0];
      mem_wdata = i2c_rx_data;
    end else if (host_grant && host_we) begin
      mem_we = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sel_d        <= 1'b0;
      ptr          <= 16'h0000;
      i2c_tx_valid <= 1'b0;
      i2c_tx_data  <= 8'h00;
      host_ack     <= 1'b0;
      host_rdata   <= 8'h00;
      wr_evt       <= 1'b0;
      wr_evt_addr  <= '0;
      wp_hit_cnt   <= '0;
      xfer_cnt     <= '0;
    end else begin
      sel_d        <= i2c_sel;
      i2c_tx_valid <= 1'b0;
      wr_evt       <= 1'b0;
      host_ack     <= 1'b0;

      if (host_grant) begin
        host_ack   <= 1'b1;
        host_rdata <= host_we ? host_wdata : mem[host_addr];
      end

      if (i2c_rd) begin
        i2c_tx_valid <= 1'b1;
        i2c_tx_data  <= mem[i2c_rd_addr];
      end

      if (i2c_wr) begin
        wr_evt      <= 1'b1;
        wr_evt_addr <= ptr[AW-1:0];
      end

      if (wp_drop)
        wp_hit_cnt <= sat_inc(wp_hit_cnt);

      // Dropping i2c_sel ends the transaction but keeps the pointer, so a
      // repeated-START read continues from the address just written.
      if (sel_drop) begin
        state    <= S_IDLE;
        xfer_cnt <= sat_inc(xfer_cnt);
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              if (i2c_rnw)
                state <= S_RD_DATA;
              else if (cfg_reg_addr_16bit)
                state <= S_ADDR_HI;
              else
                state <= S_ADDR_LO;
            end
          end
          S_ADDR_HI: begin
            if (i2c_rx_valid) begin
              ptr[15:8] <= i2c_rx_data;
              state     <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            if (i2c_rx_valid) begin
              ptr   <= {(cfg_reg_addr_16bit ? ptr[15:8] : 8'h00), i2c_rx_data};
              state <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (i2c_rx_valid)
              ptr <= ptr_adv;
          end
          S_RD_DATA: begin
            if (i2c_tx_ack)
              ptr <= ptr_adv;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: address modes, auto-increment/page wrap,
// write protection, host arbitration and reset during a read.
module tb_i2c_slave_regbank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_reg_addr_16bit, cfg_auto_inc, cfg_page_wrap, cfg_wp_en;
  logic [15:0] cfg_wp_base;
  logic        i2c_sel, i2c_rnw, i2c_rx_valid, i2c_tx_ack;
  logic [7:0]  i2c_rx_data;
  logic        i2c_tx_valid;
  logic [7:0]  i2c_tx_data;
  logic        host_req, host_we;
  logic [7:0]  host_addr, host_wdata, host_rdata;
  logic        host_ack;
  logic [15:0] ptr;
  logic        busy, wr_evt;
  logic [7:0]  wr_evt_addr;
  logic [15:0] wp_hit_cnt, xfer_cnt;

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;
  int wr_base;
  logic [7:0] rd;

  i2c_slave_regbank #(.AW(8), .PAGE_LOG2(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_reg_addr_16bit(cfg_reg_addr_16bit), .cfg_auto_inc(cfg_auto_inc),
    .cfg_page_wrap(cfg_page_wrap), .cfg_wp_en(cfg_wp_en), .cfg_wp_base(cfg_wp_base),
    .i2c_sel(i2c_sel), .i2c_rnw(i2c_rnw), .i2c_rx_valid(i2c_rx_valid),
    .i2c_rx_data(i2c_rx_data), .i2c_tx_ack(i2c_tx_ack),
    .i2c_tx_valid(i2c_tx_valid), .i2c_tx_data(i2c_tx_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ptr(ptr), .busy(busy), .wr_evt(wr_evt), .wr_evt_addr(wr_evt_addr),
    .wp_hit_cnt(wp_hit_cnt), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_evt) wr_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rnw);
    i2c_rnw = rnw;
    i2c_sel = 1'b1;
    tick();
  endtask

  task automatic stop();
    i2c_sel = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i2c_rx_data  = b;
    i2c_rx_valid = 1'b1;
    tick();
    i2c_rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic host_access(input string tag, input logic we, input logic [7:0] a,
                             input logic [7:0] wd, output logic [7:0] rdata);
    logic got;
    got        = 1'b0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (host_ack) begin
        got = 1'b1;
        break;
      end
    end
    rdata    = host_rdata;
    host_req = 1'b0;
    tick();
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_reg_addr_16bit = 1'b0; cfg_auto_inc = 1'b1; cfg_page_wrap = 1'b0;
    cfg_wp_en = 1'b0; cfg_wp_base = 16'hFFFF;
    i2c_sel = 1'b0; i2c_rnw = 1'b0; i2c_rx_valid = 1'b0; i2c_rx_data = 8'h00;
    i2c_tx_ack = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    tick();
    tick();

    chk("rst_ptr", ptr, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_tx_valid", i2c_tx_valid, 32'h0);
    chk("rst_tx_data", i2c_tx_data, 32'h0);
    chk("rst_host_ack", host_ack, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_wr_evt", wr_evt, 32'h0);
    chk("rst_wp_cnt", wp_hit_cnt, 32'h0);
    chk("rst_xfer_cnt", xfer_cnt, 32'h0);
    rst_n = 1'b1;
    tick();

    // 8-bit address write burst
    wr_base = wr_pulses;
    start(1'b0);
    chk("w8_busy", busy, 32'h1);
    send_byte(8'h10);
    chk("w8_ptr_addr", ptr, 32'h10);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    chk("w8_ptr_end", ptr, 32'h13);
    chk("w8_evt_addr", wr_evt_addr, 32'h12);
    chk("w8_evt_count", wr_pulses - wr_base, 32'd3);
    stop();
    chk("w8_xfer_cnt", xfer_cnt, 32'h1);
    chk("w8_idle", busy, 32'h0);
    chk("w8_ptr_kept", ptr, 32'h13);
    host_access("w8_rd10_ack", 1'b0, 8'h10, 8'h00, rd); chk("w8_ram10", rd, 32'hA1);
    host_access("w8_rd11_ack", 1'b0, 8'h11, 8'h00, rd); chk("w8_ram11", rd, 32'hB2);
    host_access("w8_rd12_ack", 1'b0, 8'h12, 8'h00, rd); chk("w8_ram12", rd, 32'hC3);

    // 16-bit address, repeated START read
    host_access("r16_pre3e", 1'b1, 8'h3E, 8'h5A, rd);
    host_access("r16_pre3f", 1'b1, 8'h3F, 8'h6B, rd);
    host_access("r16_pre40", 1'b1, 8'h40, 8'h7C, rd);
    cfg_reg_addr_16bit = 1'b1;
    start(1'b0);
    send_byte(8'h00);
    send_byte(8'h3E);
    chk("r16_ptr", ptr, 32'h003E);
    i2c_sel = 1'b0;
    tick();
    start(1'b1);
    chk("r16_tv0", i2c_tx_valid, 32'h1);
    chk("r16_td0", i2c_tx_data, 32'h5A);
    tick();
    chk("r16_tv_pulse", i2c_tx_valid, 32'h0);
    i2c_tx_ack = 1'b1;
    tick();
    i2c_tx_ack = 1'b0;
    chk("r16_tv1", i2c_tx_valid, 32'h1);
    chk("r16_td1", i2c_tx_data, 32'h6B);
    tick();
    i2c_tx_ack = 1'b1;
    tick();
    i2c_tx_ack = 1'b0;
    chk("r16_tv2", i2c_tx_valid, 32'h1);
    chk("r16_td2", i2c_tx_data, 32'h7C);
    chk("r16_ptr_end", ptr, 32'h0040);
    stop();
    chk("r16_xfer_cnt", xfer_cnt, 32'h3);
    cfg_reg_addr_16bit = 1'b0;

    // page wrap on, then off
    cfg_page_wrap = 1'b1;
    start(1'b0);
    send_byte(8'h0E);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("pw_ptr", ptr, 32'h01);
    stop();
    host_access("pw_rd0e_ack", 1'b0, 8'h0E, 8'h00, rd); chk("pw_ram0e", rd, 32'h11);
    host_access("pw_rd0f_ack", 1'b0, 8'h0F, 8'h00, rd); chk("pw_ram0f", rd, 32'h22);
    host_access("pw_rd00_ack", 1'b0, 8'h00, 8'h00, rd); chk("pw_ram00", rd, 32'h33);
    cfg_page_wrap = 1'b0;
    start(1'b0);
    send_byte(8'h0E);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("lin_ptr", ptr, 32'h11);
    stop();
    host_access("lin_rd10_ack", 1'b0, 8'h10, 8'h00, rd); chk("lin_ram10", rd, 32'h33);

    // write protection
    host_access("wp_pre80", 1'b1, 8'h80, 8'h00, rd);
    cfg_wp_en = 1'b1;
    cfg_wp_base = 16'h0080;
    wr_base = wr_pulses;
    start(1'b0);
    send_byte(8'h7F);
    send_byte(8'h55);
    send_byte(8'h55);
    chk("wp_ptr", ptr, 32'h81);
    stop();
    chk("wp_hit_cnt", wp_hit_cnt, 32'h1);
    chk("wp_evt_count", wr_pulses - wr_base, 32'd1);
    host_access("wp_rd7f_ack", 1'b0, 8'h7F, 8'h00, rd); chk("wp_ram7f", rd, 32'h55);
    host_access("wp_rd80_ack", 1'b0, 8'h80, 8'h00, rd); chk("wp_ram80", rd, 32'h00);
    host_access("wp_hw80_ack", 1'b1, 8'h80, 8'h66, rd);
    host_access("wp_hr80_ack", 1'b0, 8'h80, 8'h00, rd); chk("wp_host80", rd, 32'h66);

    // host read colliding with an I2C write to the same byte
    host_access("arb_pre7f", 1'b1, 8'h7F, 8'h00, rd);
    start(1'b0);
    send_byte(8'h7F);
    i2c_rx_data  = 8'h55;
    i2c_rx_valid = 1'b1;
    host_req     = 1'b1;
    host_we      = 1'b0;
    host_addr    = 8'h7F;
    tick();
    i2c_rx_valid = 1'b0;
    chk("arb_evt", wr_evt, 32'h1);
    chk("arb_evt_addr", wr_evt_addr, 32'h7F);
    chk("arb_ack_early", host_ack, 32'h0);
    tick();
    chk("arb_ack", host_ack, 32'h1);
    chk("arb_rdata", host_rdata, 32'h55);
    host_req = 1'b0;
    tick();
    chk("arb_ack_pulse", host_ack, 32'h0);
    stop();

    // reset while in RD_DATA
    start(1'b1);
    chk("rr_tv", i2c_tx_valid, 32'h1);
    chk("rr_td", i2c_tx_data, 32'h66);
    tick();
    rst_n = 1'b0;
    i2c_tx_ack = 1'b1;
    tick();
    chk("rr_busy", busy, 32'h0);
    chk("rr_ptr", ptr, 32'h0);
    chk("rr_tv_reset", i2c_tx_valid, 32'h0);
    chk("rr_xfer_cnt", xfer_cnt, 32'h0);
    chk("rr_wp_cnt", wp_hit_cnt, 32'h0);
    rst_n = 1'b1;
    i2c_tx_ack = 1'b0;
    i2c_sel = 1'b0;
    tick();
    chk("rr_tv_after", i2c_tx_valid, 32'h0);
    chk("rr_idle_after", busy, 32'h0);
    start(1'b0);
    send_byte(8'h20);
    send_byte(8'h99);
    chk("rr_ptr_new", ptr, 32'h21);
    stop();
    chk("rr_xfer_new", xfer_cnt, 32'h1);
    host_access("rr_rd20_ack", 1'b0, 8'h20, 8'h00, rd); chk("rr_ram20", rd, 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
Parametrised register-bank back end for the I2C slave protocol engine. It sits between the engine's byte interface and a RAM of configurable depth. It parses 8- or 16-bit register addresses and supports auto-increment with page wrap, a write-protected region, and a second host-side port that the USB-CDC command layer uses to read and write the same RAM. It also provides transaction status and counters for debug.

Parameters:
AW, 8, RAM index width; depth = 2^AW bytes; the pointer bits above AW alias.
PAGE_LOG2, 4, auto-increment wrap page = 2^PAGE_LOG2 bytes; must be <= AW.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cfg_reg_addr_16bit  in  1  0 = 8-bit register address, 1 = 16-bit (MSB first)
cfg_auto_inc  in  1  1 = pointer advances after every data byte
cfg_page_wrap  in  1  1 = increment wraps within the page, 0 = linear wrap at 2^16
cfg_wp_en  in  1  enable write protection
cfg_wp_base  in  16  ptr >= cfg_wp_base is read-only from I2C when cfg_wp_en = 1
i2c_sel  in  1  engine: slave addressed; low after STOP or repeated START
i2c_rnw  in  1  engine: direction bit, valid while i2c_sel = 1
i2c_rx_valid  in  1  engine: one-cycle pulse, byte received from master
i2c_rx_data  in  8  received byte
i2c_tx_ack  in  1  engine: one-cycle pulse, master ACKed the last transmitted byte
i2c_tx_valid  out  1  one-cycle pulse, i2c_tx_data is valid
i2c_tx_data  out  8  byte to send to the master
host_req  in  1  host access request; held until host_ack
host_we  in  1  1 = write
host_addr  in  AW  host RAM address
host_wdata  in  8  host write data
host_rdata  out  8  host read data, valid with host_ack
host_ack  out  1  one-cycle pulse, access complete
ptr  out  16  current register pointer
busy  out  1  state != IDLE
wr_evt  out  1  one-cycle pulse, I2C data byte committed to RAM
wr_evt_addr  out  AW  RAM index of the committed byte
wp_hit_cnt  out  CNT_W  I2C writes dropped by protection, saturating
xfer_cnt  out  CNT_W  completed transactions (i2c_sel falling edges), saturating

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE; ptr = 0; all pulse outputs = 0; i2c_tx_data = 0; host_rdata = 0; both counters = 0. RAM contents are not reset. Reset mid-transaction abandons it, and no further tx_valid is issued.
- States: IDLE, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA. sel_d is i2c_sel registered; "rise" is i2c_sel & ~sel_d.
- IDLE, on rise with rnw = 0: go to ADDR_HI if cfg_reg_addr_16bit, else ADDR_LO.
- IDLE, on rise with rnw = 1: go to RD_DATA. i2c_tx_data = RAM[ptr[AW-1:0]] and i2c_tx_valid pulse occur exactly 1 cycle after the rise cycle.
- ADDR_HI, on rx_valid: ptr[15:8] <= byte; go to ADDR_LO.
- ADDR_LO, on rx_valid: ptr[7:0] <= byte; ptr[15:8] <= 0 in 8-bit mode; go to WR_DATA.
- WR_DATA, on rx_valid:
  - If cfg_wp_en and ptr >= cfg_wp_base: no RAM write; wp_hit_cnt++.
  - Otherwise: write RAM[ptr[AW-1:0]] and pulse wr_evt in the same cycle.
  - In both cases the pointer advances.
- RD_DATA, on tx_ack: the pointer advances. The new RAM[ptr] is presented with tx_valid 1 cycle later. rx_valid in RD_DATA is ignored.
- Pointer advance when cfg_auto_inc = 0: ptr unchanged.
- Pointer advance when cfg_page_wrap = 1: the low PAGE_LOG2 bits increment modulo the page and the upper bits are unchanged (e.g. 0x0F -> 0x00 for PAGE_LOG2 = 4).
- Pointer advance otherwise: ptr + 1, modulo 2^16.
- From any non-IDLE state, i2c_sel low for one cycle: go to IDLE and xfer_cnt++; ptr is retained. Restart write-then-read therefore reads from the written address.
- Simultaneous rise and fall in one cycle cannot occur; i2c_sel low for at least 1 cycle always separates transactions.
- Arbitration: the I2C path owns the RAM in any cycle where it reads or writes. A host access is granted only in cycles with no I2C RAM access. On grant, the access executes that cycle and host_ack pulses the following cycle with host_rdata = RAM[host_addr]. Write-then-read data is read-after-write consistent.
- Write protection does not apply to the host port.
- Worst-case host latency is 3 cycles after the request, since I2C accesses are single-cycle and at least 8 SCL periods apart.
- host_req dropped before host_ack: request abandoned; no side effect unless already granted.
- Counters saturate at 2^CNT_W-1.

Test Plan:
- 8-bit mode, write 0x10, then 0xA1, 0xB2, 0xC3, STOP -> RAM[0x10..0x12] = A1, B2, C3; 3 wr_evt pulses; ptr = 0x13; xfer_cnt = 1.
- 16-bit mode, write 0x00, 0x3E, then repeated START read of 3 bytes -> tx_data 0x3E, 0x3F, 0x40 contents; each tx_valid 1 cycle after rise or tx_ack.
- Page wrap with PAGE_LOG2 = 4: write at 0x0E bytes 11, 22, 33 -> RAM[0x0E] = 11, RAM[0x0F] = 22, RAM[0x00] = 33; ptr = 0x01. With cfg_page_wrap = 0 the third byte lands at 0x10.
- cfg_wp_en = 1, cfg_wp_base = 0x80: I2C write of 0x55 to 0x7F and 0x80 -> only 0x7F is written; wp_hit_cnt = 1. A host write of 0x66 to 0x80 succeeds.
- Host read of 0x7F requested in the same cycle as I2C rx_valid -> I2C write commits first; host_ack 2 cycles later; host_rdata = 0x55.
- rst_n low during RD_DATA -> next cycle state = IDLE, busy = 0, ptr = 0, no tx_valid; a subsequent transaction behaves normally.
